btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_channel.sv | 113 +++++++++++
 rtl/btn_conditioner.sv | 34 +++
 tb/tb_btn_conditioner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the front-panel button conditioner.
package btn_pkg;

  localparam int NUM_BTN = 3;
  localparam int BTN_CFG = 0;
  localparam int BTN_INC = 1;
  localparam int BTN_DEC = 2;

  typedef enum logic [2:0] {
    IDLE,
    DEB_DN,
    PRESSED,
    HELD,
    DEB_UP
  } btn_state_e;

  // Counter width wide enough for the largest terminal count, never zero bits.
  function automatic int cnt_w(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, shared debounce/hold/repeat counter, channel FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic press_o,
  output logic level_o,
  output logic long_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_d, long_d;

  assign s = sync_q[1];

  // Two-stage synchroniser as a small shift register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[0], key_i};
  end

  // State, counter and registered pulse outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_o <= 1'b0;
      long_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_o <= press_d;
      long_o  <= long_d;
    end
  end

  // Next state; a key change always wins over the terminal count, and every
  // state change clears the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    press_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) state_d = DEB_DN;
      end
      DEB_DN: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = DEB_UP;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
          press_d = REPEAT_EN;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = DEB_UP;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d   = '0;
          press_d = REPEAT_EN;
        end
      end
      DEB_UP: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounced level is high for every state past the press debounce.
  assign level_o = (state_q == PRESSED) || (state_q == HELD) || (state_q == DEB_UP);

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the config/inc/dec buttons: one independent channel per button.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 500_000,
  parameter int                 HOLD_CYCLES     = 100_000_000,
  parameter int                 REPEAT_CYCLES   = 20_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b110
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NUM_BTN-1:0] key_i,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] long_o
);

  for (genvar ch = 0; ch < NUM_BTN; ch++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[ch])
    ) u_ch (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .key_i   (key_i[ch]),
      .press_o (press_o[ch]),
      .level_o (level_o[ch]),
      .long_o  (long_o[ch])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse events, a monitor pops them.
module tb_btn_conditioner;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] key = 3'b000;
  logic [2:0] press, level, lng;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8),
    .REPEAT_MASK     (3'b110)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .key_i   (key),
    .press_o (press),
    .level_o (level),
    .long_o  (lng)
  );

  always #5 clk = ~clk;

  // cyc == n at the negedge following active edge n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] p;
    logic [2:0] l;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  b = 0;

  function automatic int A(int r);
    return b + r - 1;
  endfunction

  task automatic goto(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(int r, logic [2:0] p, logic [2:0] l);
    ev_t e;
    e.cyc = A(r);
    e.p   = p;
    e.l   = l;
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [2:0] act, logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drain(string name);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected pulses never seen, first due cyc %0d",
               name, q.size(), q[0].cyc);
      q.delete();
    end
  endtask

  // Monitor: every pulse the DUT shows must match the head of the queue.
  always @(negedge clk) begin
    if (press != 3'b000 || lng != 3'b000) begin
      ev_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: press %b long %b at cyc %0d, none expected",
                 press, lng, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.p !== press || e.l !== lng) begin
          n_bad++;
          $display("FAIL pulse: got cyc %0d press %b long %b want cyc %0d press %b long %b",
                   cyc, press, lng, e.cyc, e.p, e.l);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with all keys held
    rstn = 1'b0;
    key  = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_press", press, 3'b000);
    chk("rst_level", level, 3'b000);
    chk("rst_long",  lng,   3'b000);
    key  = 3'b000;
    rstn = 1'b1;
    goto(cyc + 10);
    chk("post_rst_press", press, 3'b000);
    chk("post_rst_level", level, 3'b000);
    chk("post_rst_long",  lng,   3'b000);

    // Clean inc press and release
    b = cyc + 1;
    key[BTN_INC] = 1'b1;
    push(7, 3'b010, 3'b000);
    goto(A(6));  chk("inc_lvl_e6",  level, 3'b000);
    goto(A(7));  chk("inc_lvl_e7",  level, 3'b010);
    goto(A(12)); key[BTN_INC] = 1'b0;
    goto(A(18)); chk("inc_rel_e18", level, 3'b010);
    goto(A(19)); chk("inc_rel_e19", level, 3'b000);
    goto(A(25)); drain("inc_clean_drain");

    // Bounce on dec (3 high / 1 low x5), then stable high
    b = cyc + 1;
    push(27, 3'b100, 3'b000);
    for (int r = 1; r <= 34; r++) begin
      goto(A(r - 1));
      if (r - 1 == 22) chk("bounce_lvl_e22", level, 3'b000);
      if (r - 1 == 27) chk("bounce_lvl_e27", level, 3'b100);
      key[BTN_DEC] = (r > 20) || (r % 4 != 0);
    end
    goto(A(34)); key[BTN_DEC] = 1'b0;
    goto(A(40)); chk("bounce_rel_e40", level, 3'b100);
    goto(A(41)); chk("bounce_rel_e41", level, 3'b000);
    goto(A(45)); drain("bounce_drain");

    // Inc auto-repeat
    b = cyc + 1;
    key[BTN_INC] = 1'b1;
    push(7,  3'b010, 3'b000);
    push(27, 3'b010, 3'b010);
    push(35, 3'b010, 3'b000);
    push(43, 3'b010, 3'b000);
    push(51, 3'b010, 3'b000);
    push(59, 3'b010, 3'b000);
    goto(A(60)); key[BTN_INC] = 1'b0;
    goto(A(66)); chk("rep_rel_e66", level, 3'b010);
    goto(A(67)); chk("rep_rel_e67", level, 3'b000);
    goto(A(70)); drain("repeat_drain");

    // Config long press: no repeats
    b = cyc + 1;
    key[BTN_CFG] = 1'b1;
    push(7,  3'b001, 3'b000);
    push(27, 3'b000, 3'b001);
    goto(A(30)); chk("cfg_lvl_e30", level, 3'b001);
    goto(A(60)); key[BTN_CFG] = 1'b0;
    goto(A(67)); chk("cfg_rel_e67", level, 3'b000);
    goto(A(70)); drain("cfg_drain");

    // Release glitch during PRESSED restarts the hold timer
    b = cyc + 1;
    key[BTN_INC] = 1'b1;
    push(7,  3'b010, 3'b000);
    push(35, 3'b010, 3'b010);
    goto(A(10)); key[BTN_INC] = 1'b0;
    goto(A(12)); key[BTN_INC] = 1'b1;
    goto(A(13)); chk("glitch_lvl_e13", level, 3'b010);
    goto(A(14)); chk("glitch_lvl_e14", level, 3'b010);
    goto(A(40)); key[BTN_INC] = 1'b0;
    goto(A(46)); chk("glitch_rel_e46", level, 3'b010);
    goto(A(47)); chk("glitch_rel_e47", level, 3'b000);
    goto(A(50)); drain("glitch_drain");

    // Reset mid-hold, key kept held through and after reset
    b = cyc + 1;
    key[BTN_INC] = 1'b1;
    push(7,  3'b010, 3'b000);
    push(27, 3'b010, 3'b010);
    push(35, 3'b010, 3'b000);
    goto(A(39)); chk("hold_lvl_e39", level, 3'b010);
    goto(A(40));
    rstn = 1'b0;
    #1;
    chk("midrst_press", press, 3'b000);
    chk("midrst_level", level, 3'b000);
    chk("midrst_long",  lng,   3'b000);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    b = cyc + 1;
    push(7, 3'b010, 3'b000);
    goto(A(6));  chk("rerst_lvl_e6", level, 3'b000);
    goto(A(7));  chk("rerst_lvl_e7", level, 3'b010);
    goto(A(10)); key[BTN_INC] = 1'b0;
    goto(A(20));
    chk("rerst_rel_lvl", level, 3'b000);
    drain("midrst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
